load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory `MemDatos`.
- Converts byte-addressed load/store requests into word accesses on the memory. Sizes: byte, halfword, word.
- Loads are sign- or zero-extended. Sub-word stores are done as read-modify-write.
- Misaligned and out-of-range accesses are reported and never reach the memory.

Parameters:
- MEM_WORDS, 128, depth of the data memory in 32-bit words; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads (lbu/lhu); ignored for word and stores
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  2  bit0 misaligned/illegal size, bit1 out of range
- mem_addr  output  32  word index to memory = req_addr[31:2]
- mem_wdata  output  32  word to write
- mem_write  output  1  memory write enable
- mem_read  output  1  memory read enable
- mem_rdata  input  32  memory read data, combinational from mem_addr while mem_read=1

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- mem_read and mem_write are decoded from the registered state only and are never high together.
- Byte lanes are little-endian:
  - Byte lane = addr[1:0]; lane 0 = bits [7:0].
  - Halfword lane = addr[1]; lane 0 = bits [15:0].
- IDLE: req_ready=1. When req_valid=1 at a rising edge, latch all request fields and compute the word index addr[31:2]. Next state:
  - ERR_RSP if size=11, or half with addr[0]=1, or word with addr[1:0]!=0. Sets rsp_err bit0.
  - Otherwise ERR_RSP if word index >= MEM_WORDS. Sets rsp_err bit1. Misalignment takes priority; only one bit is set.
  - Otherwise WR if store and size=word; mem_wdata = req_wdata.
  - Otherwise RD.
- RD:
  - Drive mem_read=1 with mem_addr held.
  - At the edge, capture mem_rdata into an internal word register.
  - Load: go to RSP, with rsp_rdata = extracted lane, sign-extended unless req_unsigned.
  - Sub-word store: go to WR, with mem_wdata = captured word, only the addressed lane replaced by req_wdata[7:0] or [15:0].
- WR: mem_write=1 for exactly one cycle; next state RSP, rsp_rdata=0.
- RSP / ERR_RSP:
  - rsp_valid=1 for one cycle, rsp_err as latched; next state IDLE.
  - Error responses produce no memory access; rsp_rdata=0.
- rsp_rdata and rsp_err are registered and hold between responses. rsp_err clears to 0 on the next non-error response.
- Latency, counted from the accept edge T (rsp_valid high in the cycle after the listed edge):
  - Word load: T+2.
  - Byte/half load: T+2.
  - Word store: T+2.
  - Byte/half store: T+3 (RD at T+1, WR at T+2).
  - Error: T+1.
- Back-to-back: req_ready=0 in RD/WR/RSP states. The next request is accepted in the cycle after RSP. Requests held across busy cycles are not lost.
- Reset mid-operation aborts the transaction:
  - A reset asserted in RD, before WR, guarantees no memory write.
  - No partial response is issued.
- Request inputs are sampled only at accept; changes while busy are ignored.

Test Plan:
- Memory word 5 = 0x8899AABB.
  - lb addr 0x16 → rsp_rdata 0xFFFFFF99 at T+2; mem_read high 1 cycle, mem_addr 5.
  - lbu same address → 0x00000099.
- lh addr 0x16 on word 5 = 0x8899AABB → 0xFFFF8899; lhu addr 0x14 → 0x0000AABB.
- sb addr 0x15, wdata 0x00000012:
  - RD at T+1, mem_write high exactly at T+2 with mem_wdata 0x889912BB.
  - rsp_valid at T+3, rsp_err=0.
  - A following lw addr 0x14 returns 0x889912BB.
- lh addr 0x13 → rsp_err=01 at T+1, rsp_rdata=0, no mem_read/mem_write.
- lw addr 0x200 (index 128) → rsp_err=10.
- sw addr 0x200 → rsp_err=10, no mem_write.
- sh addr 0x14 accepted, then rst_n pulsed low during RD:
  - Outputs return to reset values immediately.
  - mem_write never asserts; word 5 is unchanged.
- req_valid held high with two loads queued → second accepted the cycle after the first rsp_valid; exactly two rsp_valid pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed load/store requests to a word memory.
// Ports: req_* request in, rsp_* response out, mem_* word memory side.
module load_store_unit #(
    parameter int MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RSP,
        ERR_RSP
    } state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic [31:0] wdata_q;

    logic [31:0] widx;
    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign widx = {2'b00, req_addr[31:2]};

    assign misaligned = (req_size == 2'b11)
                      || (req_size == 2'b01 && req_addr[0])
                      || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign out_of_range = widx >= 32'(MEM_WORDS);

    // Strobes and handshake come straight from the state register.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RSP) || (state == ERR_RSP);
    assign mem_read  = (state == RD);
    assign mem_write = (state == WR);

    // Little-endian lane extraction from the word being read.
    always_comb begin
        rd_byte = 8'h00;
        unique case (lane_q)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        load_val = mem_rdata;
        if (size_q == 2'b00) begin
            load_val = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
        end else if (size_q == 2'b01) begin
            load_val = {{16{rd_half[15] & ~uns_q}}, rd_half};
        end
    end

    // Read-modify-write merge: only the addressed lane is replaced.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 2'b00;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane_q  <= req_addr[1:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        if (misaligned) begin
                            rsp_err   <= 2'b01;
                            rsp_rdata <= 32'h0;
                            state     <= ERR_RSP;
                        end else if (out_of_range) begin
                            rsp_err   <= 2'b10;
                            rsp_rdata <= 32'h0;
                            state     <= ERR_RSP;
                        end else begin
                            mem_addr <= widx;
                            if (req_write && req_size == 2'b10) begin
                                mem_wdata <= req_wdata;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        mem_wdata <= merged;
                        state     <= WR;
                    end else begin
                        rsp_rdata <= load_val;
                        rsp_err   <= 2'b00;
                        state     <= RSP;
                    end
                end
                WR: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 2'b00;
                    state     <= RSP;
                end
                RSP, ERR_RSP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 128-word model memory.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];

    assign mem_rdata = (mem_read && mem_addr < 32'd128)
                     ? mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rsp_cnt = 0;
    int last_wr_cyc = -1;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory strobes and response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) chk("rd_wr_overlap", 32'd1, 32'd0);
            if (mem_read) begin
                rd_cnt++;
                last_rd_addr = mem_addr;
            end
            if (mem_write) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                last_wr_data = mem_wdata;
            end
            if (rsp_valid) begin
                exp_t e;
                rsp_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    int acc_cyc;

    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic [1:0] ee, input int lat,
                         input bit expect_rsp, input bit hold);
        int n;
        exp_t e;
        @(negedge clk);
        req_write = wr;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        acc_cyc = cyc;
        if (expect_rsp) begin
            e.rdata = er;
            e.err = ee;
            e.cyc = cyc + lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    int rd0, wr0, rs0, c0, c1;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[5] = 32'h8899_AABB;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(0, 2'b00, 0, 32'h16, 0, 32'hFFFF_FF99, 2'b00, 2, 1, 0);
        drain();
        chk("lb_reads", rd_cnt - rd0, 32'd1);
        chk("lb_rd_addr", last_rd_addr, 32'd5);
        chk("lb_writes", wr_cnt - wr0, 32'd0);

        issue(0, 2'b00, 1, 32'h16, 0, 32'h0000_0099, 2'b00, 2, 1, 0);
        issue(0, 2'b01, 0, 32'h16, 0, 32'hFFFF_8899, 2'b00, 2, 1, 0);
        issue(0, 2'b01, 1, 32'h14, 0, 32'h0000_AABB, 2'b00, 2, 1, 0);
        issue(0, 2'b00, 0, 32'h14, 0, 32'hFFFF_FFBB, 2'b00, 2, 1, 0);
        issue(0, 2'b00, 1, 32'h17, 0, 32'h0000_0088, 2'b00, 2, 1, 0);
        drain();

        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1, 2'b00, 0, 32'h15, 32'h12, 32'h0, 2'b00, 3, 1, 0);
        c0 = acc_cyc;
        drain();
        chk("sb_write_cyc", last_wr_cyc, c0 + 2);
        chk("sb_wdata", last_wr_data, 32'h8899_12BB);
        chk("sb_reads", rd_cnt - rd0, 32'd1);
        chk("sb_writes", wr_cnt - wr0, 32'd1);
        issue(0, 2'b10, 0, 32'h14, 0, 32'h8899_12BB, 2'b00, 2, 1, 0);
        drain();

        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(0, 2'b01, 0, 32'h13, 0, 32'h0, 2'b01, 1, 1, 0);
        issue(0, 2'b10, 0, 32'h200, 0, 32'h0, 2'b10, 1, 1, 0);
        issue(1, 2'b10, 0, 32'h200, 32'h5555_5555, 32'h0, 2'b10, 1, 1, 0);
        issue(0, 2'b11, 0, 32'h14, 0, 32'h0, 2'b01, 1, 1, 0);
        issue(1, 2'b10, 0, 32'h202, 0, 32'h0, 2'b01, 1, 1, 0);
        drain();
        chk("err_no_reads", rd_cnt - rd0, 32'd0);
        chk("err_no_writes", wr_cnt - wr0, 32'd0);

        wr0 = wr_cnt;
        issue(1, 2'b10, 0, 32'h10, 32'hCAFE_F00D, 32'h0, 2'b00, 2, 1, 0);
        drain();
        chk("sw_writes", wr_cnt - wr0, 32'd1);
        issue(1, 2'b01, 0, 32'h12, 32'h0000_1234, 32'h0, 2'b00, 3, 1, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 32'h1234_F00D, 2'b00, 2, 1, 0);
        drain();

        // Reset during the read phase of a halfword store.
        wr0 = wr_cnt; rs0 = rsp_cnt;
        issue(1, 2'b01, 0, 32'h14, 32'hFFFF, 32'h0, 2'b00, 0, 0, 0);
        chk("rst_mid_in_rd", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_write", wr_cnt - wr0, 32'd0);
        chk("rst_mid_no_rsp", rsp_cnt - rs0, 32'd0);
        chk("rst_mid_word5", mem[5], 32'h8899_12BB);

        // Two loads with req_valid held high throughout.
        rs0 = rsp_cnt;
        issue(0, 2'b10, 0, 32'h14, 0, 32'h8899_12BB, 2'b00, 2, 1, 1);
        c0 = acc_cyc;
        issue(0, 2'b00, 1, 32'h10, 0, 32'h0000_000D, 2'b00, 2, 1, 0);
        c1 = acc_cyc;
        drain();
        repeat (3) @(negedge clk);
        chk("b2b_accept_gap", c1 - c0, 32'd3);
        chk("b2b_rsp_count", rsp_cnt - rs0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
